// File: rtl/dmem_pkg.sv
// Shared encodings and the request error rule for the data memory responder.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Illegal size, misaligned half/word, or word index beyond the array.
    function automatic logic req_error(input logic [1:0]  size,
                                       input logic [31:0] addr,
                                       input logic [31:0] depth_words);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr[0];
            SIZE_WORD: bad = (addr[1:0] != 2'b00);
            default:   bad = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= depth_words) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: load extract/extend and store replicate/byte-enable.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word_rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data,
    output logic [3:0]  byte_en
);

    logic [31:0] shifted;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        shifted   = word_rdata >> {addr_lo, 3'b000};
        lane_byte = shifted[7:0];
        lane_half = shifted[15:0];
        load_data = 32'h0;
        case (size)
            SIZE_BYTE: load_data = is_unsigned ? {24'h0, lane_byte}
                                               : {{24{lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_data = is_unsigned ? {16'h0, lane_half}
                                               : {{16{lane_half[15]}}, lane_half};
            SIZE_WORD: load_data = word_rdata;
            default:   load_data = 32'h0;
        endcase
    end

    // Data is replicated to every lane so byte_en alone selects what lands in memory.
    always_comb begin
        store_data = 32'h0;
        byte_en    = 4'b0000;
        case (size)
            SIZE_BYTE: begin
                store_data = {4{wdata[7:0]}};
                byte_en    = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                store_data = {2{wdata[15:0]}};
                byte_en    = 4'b0011 << addr_lo;
            end
            SIZE_WORD: begin
                store_data = wdata;
                byte_en    = 4'b1111;
            end
            default: begin
                store_data = 32'h0;
                byte_en    = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: valid/ready request, wait states, one-cycle response pulse.
// Optional DMEM_ERR_LATCH_EN adds err_sticky/err_addr capturing the first error.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | req_ready high, waiting for a request
//  ST_ACCESS | wait-state countdown; memory operation on the cnt==0 edge
//  ST_RESP   | rsp_valid high for this single cycle
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_ERR_LATCH_EN
    ,
    output logic        err_sticky,
    output logic [31:0] err_addr
`endif
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        accept;
    logic        do_op;

    logic        cap_we;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic        op_err;
    logic [AW-1:0] word_idx;
    logic [31:0] word_rdata;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic [3:0]  byte_en;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_ACCESS;
            ST_ACCESS: if (cnt == 4'd0) state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        do_op     = (state == ST_ACCESS) && (cnt == 4'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= WAIT_STATES[3:0];
        end else if ((state == ST_ACCESS) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_we       <= 1'b0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_addr     <= 32'h0;
            cap_wdata    <= 32'h0;
        end else if (accept) begin
            cap_we       <= req_we;
            cap_size     <= req_size;
            cap_unsigned <= req_unsigned;
            cap_addr     <= req_addr;
            cap_wdata    <= req_wdata;
        end
    end

    assign op_err     = req_error(cap_size, cap_addr, 32'(DEPTH_WORDS));
    assign word_idx   = cap_addr[AW+1:2];
    assign word_rdata = mem[word_idx];

    dmem_lane_align u_lane_align (
        .size        (cap_size),
        .is_unsigned (cap_unsigned),
        .addr_lo     (cap_addr[1:0]),
        .word_rdata  (word_rdata),
        .wdata       (cap_wdata),
        .load_data   (load_data),
        .store_data  (store_data),
        .byte_en     (byte_en)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (do_op) begin
            rsp_err   <= op_err;
            rsp_rdata <= (op_err || cap_we) ? 32'h0 : load_data;
        end
    end

    // Array is deliberately not reset so contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (do_op && cap_we && !op_err && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_ERR_LATCH_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky <= 1'b0;
            err_addr   <= 32'h0;
        end else if (do_op && op_err && !err_sticky) begin
            err_sticky <= 1'b1;
            err_addr   <= cap_addr;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        z_valid = 1'b0;
    logic        z_ready;
    logic        z_rsp_valid;
    logic [31:0] z_rsp_rdata;
    logic        z_rsp_err;

`ifdef DMEM_ERR_LATCH_EN
    logic        err_sticky;
    logic [31:0] err_addr;
    logic        z_err_sticky;
    logic [31:0] z_err_addr;
`endif

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
`ifdef DMEM_ERR_LATCH_EN
        ,
        .err_sticky   (err_sticky),
        .err_addr     (err_addr)
`endif
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (z_valid),
        .req_ready    (z_ready),
        .req_we       (1'b1),
        .req_size     (2'b10),
        .req_unsigned (1'b0),
        .req_addr     (32'h0),
        .req_wdata    (32'h0),
        .rsp_valid    (z_rsp_valid),
        .rsp_rdata    (z_rsp_rdata),
        .rsp_err      (z_rsp_err)
`ifdef DMEM_ERR_LATCH_EN
        ,
        .err_sticky   (z_err_sticky),
        .err_addr     (z_err_addr)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  model_mem [0:4*DEPTH-1];
    logic        model_sticky = 1'b0;
    logic [31:0] model_err_addr = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] nbytes;
        nbytes = 32'd1 << size;
        if (size == 2'd3) return 1'b1;
        if (addr >= 32'(4 * DEPTH)) return 1'b1;
        if ((addr % nbytes) != 32'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr);
        int          n;
        logic [31:0] v;
        n = 1 << size;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(model_mem[addr + 32'(i)]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   guard;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready stuck at 0 for addr 0x%08h", addr);
            req_valid = 1'b0;
            return;
        end
        e.err   = model_err(size, addr);
        e.rdata = 32'h0;
        if (!e.err) begin
            if (we) begin
                for (int i = 0; i < (1 << size); i++)
                    model_mem[addr + 32'(i)] = wdata[8*i +: 8];
            end else begin
                e.rdata = model_load(size, uns, addr);
            end
        end
        if (e.err && !model_sticky) begin
            model_sticky   = 1'b1;
            model_err_addr = addr;
        end
        e.cyc = cyc + 2 + WS;
        q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && rsp_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          kind;

        #2;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
`ifdef DMEM_ERR_LATCH_EN
        check("reset_err_sticky", 32'(err_sticky), 32'd0);
        check("reset_err_addr", err_addr, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int w = 0; w < 32; w++) issue(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom);

        // directed: word store, lane loads, partial store
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h55);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        drain();
        check("model_word_0x10", model_load(2'b10, 1'b0, 32'h10), 32'hDEAD55EF);

        issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF);
        issue(1'b1, 2'b10, 1'b0, 32'h400, 32'hFFFF_FFFF);
        issue(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        drain();
`ifdef DMEM_ERR_LATCH_EN
        check("err_sticky_after_errs", 32'(err_sticky), 32'd1);
        check("err_addr_after_errs", err_addr, 32'h12);
`endif

        // reset while the store sits in ACCESS: must be dropped
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
        check("pre_abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_access_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_rdata", rsp_rdata, 32'h0);
`ifdef DMEM_ERR_LATCH_EN
        check("abort_err_sticky", 32'(err_sticky), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        model_sticky   = 1'b0;
        model_err_addr = 32'h0;
        repeat (5) @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        drain();

        for (int t = 0; t < 80; t++) begin
            kind = int'($urandom_range(0, 9));
            sz   = 2'($urandom_range(0, 3));
            if (kind < 8) a = 32'($urandom_range(0, 127));
            else          a = 32'h400 | $urandom;
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        drain();
`ifdef DMEM_ERR_LATCH_EN
        check("final_err_sticky", 32'(err_sticky), 32'(model_sticky));
        check("final_err_addr", err_addr, model_err_addr);
`endif

        // back-to-back with no wait states: ready 1,0,0 and a pulse every third cycle
        @(negedge clk);
        z_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("ws0_req_ready", 32'(z_ready), (k % 3 == 0) ? 32'd1 : 32'd0);
            check("ws0_rsp_valid", 32'(z_rsp_valid), (k % 3 == 2) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        z_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
